// File: rtl/uart_frame_tx_pkg.sv
// Shared framing constants, FSM encoding and baud derivation for the host UART
// command/response path.
package uart_frame_tx_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;
    localparam int CHAR_BITS        = 10;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_FREQ, DEFAULT_BAUD);

    localparam logic [7:0] FRAME_HDR0 = 8'h55;
    localparam logic [7:0] FRAME_HDR1 = 8'h5D;
    localparam logic [7:0] FRAME_TR0  = 8'h0D;
    localparam logic [7:0] FRAME_TR1  = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_TR0,
        ST_TR1,
        ST_DONE
    } frame_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first character serializer. byte_ready rises in the last cycle of the
// stop bit so a waiting byte starts the next start bit with no idle gap.
module uart_tx_byte
    import uart_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(CHAR_BITS - 1);

    logic          active;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign byte_ready = !active || (bit_end && (bit_idx == BIT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= byte_in;
            tx       <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_idx == BIT_LAST) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    // Slot k+1 carries data bit k; slot 9 is the stop bit.
                    tx      <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
                end
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Response-frame transmitter: 55 5D cmd len payload[len] 0D 0A on tx, one byte
// per FSM state, handed to uart_tx_byte.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    frame_state_t state;
    logic [7:0]   cmd_q;
    logic [7:0]   len_q;
    logic [7:0]   remaining;
    logic         fix_valid;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         accept;

    always_comb begin
        byte_in = FRAME_HDR0;
        case (state)
            ST_HDR1: byte_in = FRAME_HDR1;
            ST_CMD:  byte_in = cmd_q;
            ST_LEN:  byte_in = len_q;
            ST_DATA: byte_in = pl_data;
            ST_TR0:  byte_in = FRAME_TR0;
            ST_TR1:  byte_in = FRAME_TR1;
            default: byte_in = FRAME_HDR0;
        endcase
    end

    assign byte_valid = (state == ST_DATA) ? pl_valid : fix_valid;
    assign pl_ready   = (state == ST_DATA) && byte_ready;
    assign accept     = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            len_q     <= '0;
            remaining <= '0;
            fix_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The done cycle is not an accept cycle; start opens again after it.
                    if (start && !done) begin
                        cmd_q     <= cmd;
                        len_q     <= len;
                        remaining <= len;
                        busy      <= 1'b1;
                        state     <= ST_HDR0;
                    end
                end
                ST_HDR0: begin
                    // One cycle of settle before offering 0x55 puts its start bit
                    // two clocks after the start sample.
                    fix_valid <= 1'b1;
                    if (accept) state <= ST_HDR1;
                end
                ST_HDR1: if (accept) state <= ST_CMD;
                ST_CMD:  if (accept) state <= ST_LEN;
                ST_LEN: begin
                    if (accept) begin
                        if (len_q == 8'd0) begin
                            state <= ST_TR0;
                        end else begin
                            state     <= ST_DATA;
                            fix_valid <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state     <= ST_TR0;
                            fix_valid <= 1'b1;
                        end
                    end
                end
                ST_TR0: if (accept) state <= ST_TR1;
                ST_TR1: begin
                    if (accept) begin
                        state     <= ST_DONE;
                        fix_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (byte_ready) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx        (tx)
    );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx at 10 clk per bit: table of frames plus hand-written
// busy-restart and mid-frame reset sequences, with a tx line decoder.
`timescale 1ns/1ps
module tb_uart_frame_tx;

    localparam int CPB  = 10;
    localparam int CHAR = 10 * CPB;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] len;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        int         stall_idx;
        int         stall_cycles;
        bit         poke;
        int         exp_clks;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] len = 8'h00;
    logic [7:0] pl_data = 8'h00;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic       busy;
    logic       done;
    logic       tx;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t_q[$];

    bit         mon_clear = 1'b0;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         rx_t0 = 0;
    logic [7:0] rx_sh = 8'h00;

    int         drv_len = 0;
    int         drv_idx = 0;
    int         drv_stall_idx = -1;
    int         drv_stall_left = 0;
    logic [7:0] drv_pl[256];

    vec_t vecs[6];

    uart_frame_tx #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cmd     (cmd),
        .len     (len),
        .pl_data (pl_data),
        .pl_valid(pl_valid),
        .pl_ready(pl_ready),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] payload_byte(input vec_t v, input int i);
        case (i)
            0: return v.p0;
            1: return v.p1;
            2: return v.p2;
            default: return 8'((i * 29 + 7) & 255);
        endcase
    endfunction

    // ---------------- tx line decoder ----------------
    initial forever begin
        @(negedge clk);
        if (mon_clear) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_t0   = cyc;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB / 2 && ((rx_cnt - CPB / 2) % CPB) == 0) begin
                int k;
                k = (rx_cnt - CPB / 2) / CPB;
                if (k == 0) begin
                    check("start_bit", 32'(tx), 32'd0);
                end else if (k <= 8) begin
                    rx_sh[k-1] = tx;
                end else begin
                    check("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(rx_sh);
                    rx_t_q.push_back(rx_t0);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- payload driver ----------------
    initial forever begin
        @(negedge clk);
        if (drv_idx < drv_len && !(drv_idx == drv_stall_idx && drv_stall_left > 0)) begin
            pl_valid = 1'b1;
            pl_data  = drv_pl[drv_idx];
        end else begin
            pl_valid = 1'b0;
            pl_data  = 8'($urandom_range(0, 255));
        end
        if (pl_ready) begin
            if (pl_valid) drv_idx++;
            else if (drv_idx == drv_stall_idx && drv_stall_left > 0) drv_stall_left--;
        end
    end

    // ---------------- one full frame with scoreboard ----------------
    task automatic run_frame(input vec_t v, input string tag);
        int s;
        int budget;
        int done_seen;
        int done_t;
        int busy_bad;
        int rdy_cnt;
        int stall;
        int t_exp;
        bit poke_on;

        exp_q.delete();
        rx_q.delete();
        rx_t_q.delete();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h5D);
        exp_q.push_back(v.cmd);
        exp_q.push_back(v.len);
        for (int i = 0; i < int'(v.len); i++) begin
            drv_pl[i] = payload_byte(v, i);
            exp_q.push_back(drv_pl[i]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);

        drv_idx        = 0;
        drv_len        = int'(v.len);
        drv_stall_idx  = v.stall_idx;
        drv_stall_left = v.stall_cycles;
        stall          = (v.stall_idx >= 0) ? v.stall_cycles : 0;

        @(negedge clk);
        start = 1'b1;
        cmd   = v.cmd;
        len   = v.len;
        @(negedge clk);
        s     = cyc;
        start = 1'b0;
        cmd   = 8'($urandom_range(0, 255));
        len   = 8'($urandom_range(0, 255));
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);

        budget    = v.exp_clks + 2 + 3 * CPB;
        done_seen = 0;
        done_t    = -1;
        busy_bad  = 0;
        rdy_cnt   = 0;
        poke_on   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (poke_on) begin
                start   = 1'b0;
                poke_on = 1'b0;
            end
            if (v.poke && cyc == s + 2 + 2 * CHAR + CHAR / 2) begin
                start   = 1'b1;
                cmd     = ~v.cmd;
                len     = 8'(v.len + 8'd1);
                poke_on = 1'b1;
            end
            if (done === 1'b1) begin
                done_seen++;
                if (done_t < 0) done_t = cyc;
            end
            if (busy !== (done_t < 0)) busy_bad++;
            if (pl_ready === 1'b1) rdy_cnt++;
        end

        check({tag, " done_count"}, 32'(done_seen), 32'd1);
        check({tag, " done_time"}, 32'(done_t), 32'(s + 2 + v.exp_clks));
        check({tag, " busy_profile_errors"}, 32'(busy_bad), 32'd0);
        check({tag, " payload_transfers"}, 32'(drv_idx), 32'(v.len));
        if (v.len == 8'd0) check({tag, " pl_ready_cycles"}, 32'(rdy_cnt), 32'd0);
        check({tag, " tx_idle_after"}, 32'(tx), 32'd1);
        check({tag, " byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                t_exp = s + 2 + i * CHAR + ((v.stall_idx >= 0 && i >= 4 + v.stall_idx) ? stall : 0);
                check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
                check($sformatf("%s start_time%0d", tag, i), 32'(rx_t_q[i]), 32'(t_exp));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s;
        int target;
        int done_seen;
        int busy_bad;
        int tx_bad;
        vec_t fresh;

        // cmd, len, p0, p1, p2, stall_idx, stall_cycles, poke, exp_clks
        vecs[0] = '{8'h01, 8'd2,   8'hAA, 8'h55, 8'h00, -1, 0,    1'b0, 800};
        vecs[1] = '{8'hAA, 8'd0,   8'h00, 8'h00, 8'h00, -1, 0,    1'b0, 600};
        vecs[2] = '{8'h5A, 8'd3,   8'h11, 8'h22, 8'h33,  1, 1000, 1'b0, 1900};
        vecs[3] = '{8'h01, 8'd2,   8'hAA, 8'h55, 8'h00, -1, 0,    1'b1, 800};
        vecs[4] = '{8'h01, 8'd1,   8'h02, 8'h00, 8'h00, -1, 0,    1'b0, 700};
        vecs[5] = '{8'hC3, 8'd255, 8'hFF, 8'h00, 8'h80, -1, 0,    1'b0, 26100};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pl_ready", 32'(pl_ready), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Reset during the third data bit of the LEN character.
        drv_idx       = 0;
        drv_len       = 2;
        drv_pl[0]     = 8'h99;
        drv_pl[1]     = 8'h66;
        drv_stall_idx = -1;
        @(negedge clk);
        start = 1'b1;
        cmd   = 8'h3C;
        len   = 8'd2;
        @(negedge clk);
        s      = cyc;
        start  = 1'b0;
        target = s + 2 + 3 * CHAR + 3 * CPB + CPB / 2;
        for (int c = 0; c < 5 * CHAR; c++) begin
            if (cyc >= target) break;
            @(negedge clk);
        end
        check("rst_mid reached", 32'(cyc), 32'(target));
        check("rst_mid tx_before", 32'(tx), 32'd0);
        rst       = 1'b1;
        mon_clear = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid tx", 32'(tx), 32'd1);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid pl_ready", 32'(pl_ready), 32'd0);
        @(negedge clk);
        mon_clear = 1'b0;
        drv_len   = 0;
        done_seen = 0;
        busy_bad  = 0;
        tx_bad    = 0;
        for (int c = 0; c < 3 * CHAR; c++) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
            if (busy !== 1'b0) busy_bad++;
            if (tx !== 1'b1) tx_bad++;
        end
        check("rst_mid no_done", 32'(done_seen), 32'd0);
        check("rst_mid stays_idle", 32'(busy_bad), 32'd0);
        check("rst_mid tx_quiet", 32'(tx_bad), 32'd0);

        fresh = '{8'h7E, 8'd2, 8'h0D, 8'h0A, 8'h00, -1, 0, 1'b0, 800};
        run_frame(fresh, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Response-path counterpart of the host-command UART receiver.
- Packs a response frame and serializes it on FPGA_TX as 8N1 LSB-first UART at 115200 baud from the 50 MHz clk.
- Frame format matches the command framing: 0x55, 0x5D, cmd, len, len payload bytes, 0x0D, 0x0A.
- Sits between the command/RFFE control logic (payload source) and the FPGA_TX pin.

Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 434), clk cycles per UART bit.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to send one frame.
- cmd  in  8  command/status byte, latched on an accepted start.
- len  in  8  payload byte count 0..255, latched on an accepted start.
- pl_data  in  8  payload byte.
- pl_valid  in  1  pl_data is valid.
- pl_ready  out  1  block consumes pl_data on this cycle when pl_valid=1.
- busy  out  1  frame in progress.
- done  out  1  single-cycle pulse after the last stop bit of the frame.
- tx  out  1  serial line, connected to FPGA_TX; idles high.

Behaviour:
- Reset values: tx=1, busy=0, done=0, pl_ready=0. Serializer is idle and bit/baud counters are 0.
- rst asserted mid-frame: tx=1 on the next edge, the frame is abandoned, no done pulse, and the block returns to IDLE.
- Start acceptance: start is sampled only in IDLE (busy=0). An accepted start sets busy=1 on the next edge and latches cmd and len. A start while busy=1 is ignored and not queued.
- Frame FSM states: IDLE -> HDR0(0x55) -> HDR1(0x5D) -> CMD -> LEN -> DATA (len times; skipped if len=0) -> TR0(0x0D) -> TR1(0x0A) -> DONE -> IDLE.
- Each FSM state hands one byte to the serializer. The FSM advances when the serializer accepts the byte.
- Timing: the start bit of 0x55 begins exactly 2 clk after the edge that sampled start.
- Character timing: each character is 10 bits (start 0, 8 data LSB-first, stop 1), and each bit lasts exactly CLKS_PER_BIT clk.
- Back-to-back bytes have no idle gap when the next byte is available.
- Frame duration with no stalls: (6+len)*10*CLKS_PER_BIT clk.
- DATA handshake:
  - pl_ready=1 only in DATA when the serializer can take a byte, i.e. in the cycle the previous stop bit completes, or immediately on entering DATA.
  - A transfer occurs when pl_valid and pl_ready are both 1 in the same cycle.
  - If pl_valid=0, pl_ready holds 1 and tx holds 1 (idle gap) until pl_valid=1. There is no timeout.
  - The payload counter counts down from len. The FSM leaves DATA after the len-th transfer.
- DONE: done=1 for exactly one cycle, coinciding with the first cycle after the final stop bit of 0x0A. busy drops to 0 in the same cycle. start is accepted again from the following cycle.
- Widths: baud counter ceil(log2(CLKS_PER_BIT)) bits, bit index 4 bits, payload counter 8 bits. No wrap: len=255 sends exactly 255 payload bytes.

Decomposition:
- Shared package/header holds:
  - FRAME_HDR0=8'h55, FRAME_HDR1=8'h5D, FRAME_TR0=8'h0D, FRAME_TR1=8'h0A.
  - The FSM state encodings.
  - The CLKS_PER_BIT derivation.
- The command receiver uses the same constants.
- One sub-module: uart_tx_byte. Interface is clk, rst, byte_in[7:0], byte_valid, byte_ready, tx, with the CLKS_PER_BIT parameter. It handles only the 10-bit character timing; framing stays in uart_frame_tx.

Test Plan:
- start with cmd=0x01, len=2, payload 0xAA,0x55 always valid -> tx carries 55 5D 01 02 AA 55 0D 0A. Each bit is exactly 434 clk (8680 ns). done pulses once, 34720 clk after the first start bit. busy=1 throughout.
- len=0, cmd=0xAA -> tx carries 55 5D AA 00 0D 0A. pl_ready never asserts. Frame length is 26040 clk.
- len=3 with pl_valid held low for 1000 clk before the 2nd payload byte -> tx stays high 1000 clk after that byte's preceding stop bit. Bytes are then uncorrupted and the payload order is preserved.
- start pulsed again while busy (e.g. during CMD) with different cmd/len -> ignored. The frame completes with the original values and only one done pulse occurs.
- rst asserted during the 3rd data bit of the LEN byte -> tx=1 next cycle, busy=0, no done. A fresh start afterwards produces a complete, correct frame.
- Loopback of tx into the existing UART command receiver, cmd=0x01, len=1, payload 0x02 -> receiver decodes a well-formed frame with matching header and trailer bytes.
